// File: rtl/axil_char_write_40bit.sv
// axil_char_write_40bit: AXI4-Lite slave that collects a 40-bit character word
// through two register writes and presents it on a valid/ready stream.
//
// Register window (word address = addr[3:2]):
//   0x0 CHAR_LO  RW  [31:0]
//   0x4 CHAR_HI  RW  [7:0]
//   0x8 CTRL     bit0 COMMIT (write-1-to-pulse, reads 0), bit1 AUTO (RW),
//                bit31 written as 1 clears STATUS.OVF
//   0xC STATUS   RO  [15:0] commit count, [30] pending, [31] OVF (sticky)
//
// Optional build macro AXIL_CHAR_SLVERR_EN: a non word-aligned access answers
// SLVERR, a misaligned write has no effect and a misaligned read returns 0.
//
// Handshake rule for every channel: a transfer happens on the rising ACLK edge
// where VALID and READY are both 1; a VALID, once raised, holds its payload
// until that edge.
module axil_char_write_40bit #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic [2:0]                    S_AXI_AWPROT,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
  input  logic [3:0]                    S_AXI_WSTRB,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [2:0]                    S_AXI_ARPROT,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  output logic [39:0]                   char_data,
  output logic                          char_valid,
  input  logic                          char_ready
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Channel state
  logic        en_q;          // low during and for one edge after reset so READYs start at 0
  logic        aw_q, w_q;
  logic [3:0]  awaddr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        bvalid_q;
  logic [1:0]  bresp_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;

  // Register file and character output
  logic [31:0] lo_q, lo_d;
  logic [7:0]  hi_q, hi_d;
  logic        auto_q, auto_d;
  logic        ovf_q;
  logic [15:0] cnt_q;
  logic [39:0] cdata_q;
  logic        cvalid_q;

  // Combinational helpers
  logic        awready, wready, arready;
  logic        aw_hs, w_hs, ar_hs;
  logic [3:0]  wa_addr;
  logic [31:0] wd;
  logic [3:0]  ws;
  logic        wr_fire, wr_err, wr_en;
  logic [1:0]  wsel;
  logic        commit, accept, ovf_clr;
  logic [31:0] rd_word;
  logic        rd_err;
  logic        unused_sig;

  assign awready = en_q & ~aw_q & ~bvalid_q;
  assign wready  = en_q & ~w_q  & ~bvalid_q;
  assign arready = en_q & ~rvalid_q;
  assign aw_hs   = S_AXI_AWVALID & awready;
  assign w_hs    = S_AXI_WVALID  & wready;
  assign ar_hs   = S_AXI_ARVALID & arready;

  // The write executes on the edge where the later of AW/W arrives, so the
  // just-arriving payload is forwarded past its latch.
  assign wa_addr = aw_q ? awaddr_q : S_AXI_AWADDR[3:0];
  assign wd      = w_q  ? wdata_q  : S_AXI_WDATA[31:0];
  assign ws      = w_q  ? wstrb_q  : S_AXI_WSTRB;
  assign wr_fire = (aw_q | aw_hs) & (w_q | w_hs) & ~bvalid_q;
  assign wsel    = wa_addr[3:2];

`ifdef AXIL_CHAR_SLVERR_EN
  assign wr_err = wr_fire & (wa_addr[1:0] != 2'b00);
  assign rd_err = (S_AXI_ARADDR[1:0] != 2'b00);
`else
  assign wr_err = 1'b0;
  assign rd_err = 1'b0;
`endif

  assign wr_en   = wr_fire & ~wr_err;
  // COMMIT and AUTO live in byte 0, the OVF clear bit in byte 3.
  assign commit  = wr_en & ws[0] & (((wsel == 2'd2) & wd[0]) | ((wsel == 2'd1) & auto_q));
  assign ovf_clr = wr_en & ws[3] & (wsel == 2'd2) & wd[31];
  // A committed word is taken when the output slot is empty or draining this edge.
  assign accept  = commit & (~cvalid_q | char_ready);

  assign unused_sig = ^{S_AXI_AWPROT, S_AXI_ARPROT, wa_addr[1:0], S_AXI_ARADDR[1:0]};

  // Post-write register values with per-byte strobes
  always_comb begin
    lo_d   = lo_q;
    hi_d   = hi_q;
    auto_d = auto_q;
    if (wr_en) begin
      case (wsel)
        2'd0: begin
          for (int b = 0; b < 4; b++) begin
            if (ws[b]) lo_d[8*b +: 8] = wd[8*b +: 8];
          end
        end
        2'd1: if (ws[0]) hi_d = wd[7:0];
        2'd2: if (ws[0]) auto_d = wd[1];
        default: ;
      endcase
    end
  end

  // Read mux sampled at the AR handshake; sees pre-write register values
  always_comb begin
    rd_word = 32'd0;
    case (S_AXI_ARADDR[3:2])
      2'd0: rd_word = lo_q;
      2'd1: rd_word = {24'd0, hi_q};
      2'd2: rd_word = {30'd0, auto_q, 1'b0};
      2'd3: rd_word = {ovf_q, cvalid_q, 14'd0, cnt_q};
      default: rd_word = 32'd0;
    endcase
    if (rd_err) rd_word = 32'd0;
  end

  // Write address/data latches and write response
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      en_q     <= 1'b0;
      aw_q     <= 1'b0;
      w_q      <= 1'b0;
      awaddr_q <= 4'd0;
      wdata_q  <= 32'd0;
      wstrb_q  <= 4'd0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else begin
      en_q <= 1'b1;
      if (aw_hs) begin
        aw_q     <= 1'b1;
        awaddr_q <= S_AXI_AWADDR[3:0];
      end
      if (w_hs) begin
        w_q     <= 1'b1;
        wdata_q <= S_AXI_WDATA[31:0];
        wstrb_q <= S_AXI_WSTRB;
      end
      if (wr_fire) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end else if (bvalid_q && S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
        aw_q     <= 1'b0;
        w_q      <= 1'b0;
      end
    end
  end

  // Register file update
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      lo_q   <= 32'd0;
      hi_q   <= 8'd0;
      auto_q <= 1'b0;
    end else begin
      lo_q   <= lo_d;
      hi_q   <= hi_d;
      auto_q <= auto_d;
    end
  end

  // Character output slot, commit counter and overflow flag
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      cdata_q  <= 40'd0;
      cvalid_q <= 1'b0;
      cnt_q    <= 16'd0;
      ovf_q    <= 1'b0;
    end else begin
      if (ovf_clr) ovf_q <= 1'b0;
      // A dropped commit in the same write as the clear leaves OVF set.
      if (commit && !accept) ovf_q <= 1'b1;
      if (accept) begin
        cdata_q  <= {hi_d, lo_d};
        cvalid_q <= 1'b1;
        cnt_q    <= cnt_q + 16'd1;
      end else if (cvalid_q && char_ready) begin
        cvalid_q <= 1'b0;
      end
    end
  end

  // Read channel: one-cycle latency, data held until RREADY
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rvalid_q <= 1'b0;
      rdata_q  <= 32'd0;
      rresp_q  <= RESP_OKAY;
    end else begin
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_word;
        rresp_q  <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end else if (rvalid_q && S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign S_AXI_AWREADY = awready;
  assign S_AXI_WREADY  = wready;
  assign S_AXI_ARREADY = arready;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign char_data     = cdata_q;
  assign char_valid    = cvalid_q;

endmodule

// File: tb/tb_axil_char_write_40bit.sv
// Testbench for axil_char_write_40bit: directed AXI4-Lite traffic with a
// scoreboard of expected R, B and character-stream responses.
module tb_axil_char_write_40bit;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [3:0]  S_AXI_AWADDR;
  logic [2:0]  S_AXI_AWPROT;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [3:0]  S_AXI_ARADDR;
  logic [2:0]  S_AXI_ARPROT;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;
  logic [39:0] char_data;
  logic        char_valid;
  logic        char_ready;

  int total = 0;
  int bad   = 0;

  logic [33:0] rq[$];   // {rresp, rdata}
  logic [1:0]  bq[$];   // bresp
  logic [39:0] cq[$];   // char word

  axil_char_write_40bit dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .char_data(char_data), .char_valid(char_valid), .char_ready(char_ready)
  );

  // Clock
  always #5 ACLK = ~ACLK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timeout waiting for DUT", nm);
  endtask

  // Monitor: pops the scoreboard whenever a handshake is about to complete
  always @(negedge ACLK) begin
    if (!ARESET) begin
      if (S_AXI_RVALID && S_AXI_RREADY) begin
        if (rq.size() == 0) timeout("r_unexpected");
        else chk("r_resp_data", {S_AXI_RRESP, S_AXI_RDATA}, rq.pop_front());
      end
      if (S_AXI_BVALID && S_AXI_BREADY) begin
        if (bq.size() == 0) timeout("b_unexpected");
        else chk("b_resp", S_AXI_BRESP, bq.pop_front());
      end
      if (char_valid && char_ready) begin
        if (cq.size() == 0) timeout("char_unexpected");
        else chk("char_data", char_data, cq.pop_front());
      end
    end
  end

  task automatic do_reset();
    @(posedge ACLK); #1;
    ARESET = 1'b1;
    @(negedge ACLK);
    chk("rst_readys", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
    chk("rst_valids", {S_AXI_BVALID, S_AXI_RVALID, char_valid}, 3'b000);
    chk("rst_payload", {S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA}, 36'd0);
    chk("rst_char_data", char_data, 40'd0);
    @(posedge ACLK); #1;
    ARESET = 1'b0;
  endtask

  task automatic wait_b(input string nm);
    int n = 0;
    @(negedge ACLK);
    while (!S_AXI_BVALID && n < 50) begin @(negedge ACLK); n++; end
    if (n >= 50) timeout(nm);
    @(posedge ACLK); #1;
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [1:0] exp_resp);
    int n = 0;
    logic aw_ok, w_ok;
    bq.push_back(exp_resp);
    S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    while ((S_AXI_AWVALID || S_AXI_WVALID) && n < 50) begin
      @(negedge ACLK);
      aw_ok = S_AXI_AWREADY; w_ok = S_AXI_WREADY;
      @(posedge ACLK); #1;
      if (aw_ok) S_AXI_AWVALID = 1'b0;
      if (w_ok)  S_AXI_WVALID  = 1'b0;
      n++;
    end
    if (n >= 50) begin
      timeout("aw_w_accept");
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    end
    wait_b("b_valid");
  endtask

  task automatic axi_read(input logic [3:0] a, input logic [31:0] exp_d, input logic [1:0] exp_r);
    int n = 0;
    rq.push_back({exp_r, exp_d});
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
    @(negedge ACLK);
    while (!S_AXI_ARREADY && n < 50) begin @(negedge ACLK); n++; end
    if (n >= 50) timeout("ar_accept");
    @(posedge ACLK); #1;
    S_AXI_ARVALID = 1'b0;
    n = 0;
    @(negedge ACLK);
    while (!S_AXI_RVALID && n < 50) begin @(negedge ACLK); n++; end
    if (n >= 50) timeout("r_valid");
    @(posedge ACLK); #1;
  endtask

  // W three cycles ahead of AW (or together when early_w=0), BREADY low 5 cycles
  task automatic split_write(input logic early_w, input logic [3:0] a, input logic [31:0] d);
    bq.push_back(2'b00);
    S_AXI_BREADY = 1'b0;
    S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = 4'hF;
    S_AXI_WVALID = 1'b1;
    if (early_w) begin
      @(negedge ACLK);
      chk("early_wready", S_AXI_WREADY, 1'b1);
      @(posedge ACLK); #1;
      S_AXI_WVALID = 1'b0;
      for (int i = 0; i < 2; i++) begin
        @(negedge ACLK);
        chk("w_latched_wready", {S_AXI_WREADY, S_AXI_AWREADY, S_AXI_BVALID}, 3'b010);
        @(posedge ACLK); #1;
      end
    end
    S_AXI_AWVALID = 1'b1;
    @(negedge ACLK);
    chk("aw_ready", S_AXI_AWREADY, 1'b1);
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      chk("b_held", {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY}, 3'b100);
      @(posedge ACLK); #1;
    end
    S_AXI_BREADY = 1'b1;
    wait_b("split_b");
    @(negedge ACLK);
    chk("b_cleared", S_AXI_BVALID, 1'b0);
    @(posedge ACLK); #1;
  endtask

  // Stimulus
  initial begin
    ARESET = 1'b1;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0;
    S_AXI_BREADY = 1'b1;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY = 1'b1;
    char_ready = 1'b0;
    do_reset();

    // Plain register writes and read-back, no commit
    axi_write(4'h0, 32'h11223344, 4'hF, 2'b00);
    axi_write(4'h4, 32'h000000AA, 4'hF, 2'b00);
    axi_read(4'h0, 32'h11223344, 2'b00);
    axi_read(4'h4, 32'h000000AA, 2'b00);
    chk("no_commit_valid", char_valid, 1'b0);

    // Explicit commit with a ready sink: one-cycle pulse
    char_ready = 1'b1;
    cq.push_back(40'hAA11223344);
    axi_write(4'h8, 32'h00000001, 4'hF, 2'b00);
    chk("commit_pulse_gone", char_valid, 1'b0);
    axi_read(4'hC, 32'h00000001, 2'b00);
    axi_read(4'h8, 32'h00000000, 2'b00);

    // Byte strobes
    axi_write(4'h0, 32'hFFFFFFFF, 4'b0101, 2'b00);
    axi_read(4'h0, 32'h11FF33FF, 2'b00);
    axi_write(4'h0, 32'hFFFFFFFF, 4'b0000, 2'b00);
    axi_read(4'h0, 32'h11FF33FF, 2'b00);

    // Channel ordering with held response; each commits exactly once
    cq.push_back(40'hAA11FF33FF);
    split_write(1'b1, 4'h8, 32'h00000001);
    cq.push_back(40'hAA11FF33FF);
    split_write(1'b0, 4'h8, 32'h00000001);
    axi_read(4'hC, 32'h00000003, 2'b00);

    // AUTO commit, overflow, overflow clear
    char_ready = 1'b0;
    do_reset();
    axi_read(4'hC, 32'h00000000, 2'b00);
    axi_write(4'h0, 32'h11223344, 4'hF, 2'b00);
    axi_write(4'h8, 32'h00000002, 4'hF, 2'b00);
    axi_write(4'h4, 32'h00000055, 4'hF, 2'b00);
    chk("auto_valid", char_valid, 1'b1);
    chk("auto_data", char_data, 40'h5511223344);
    axi_write(4'h4, 32'h00000066, 4'hF, 2'b00);
    chk("drop_data", char_data, 40'h5511223344);
    axi_read(4'hC, 32'hC0000001, 2'b00);
    axi_read(4'h4, 32'h00000066, 2'b00);
    axi_write(4'h8, 32'h80000002, 4'hF, 2'b00);
    axi_read(4'hC, 32'h40000001, 2'b00);
    axi_read(4'h8, 32'h00000002, 2'b00);
    cq.push_back(40'h5511223344);
    char_ready = 1'b1;
    @(posedge ACLK); #1;
    @(negedge ACLK);
    chk("drained_valid", char_valid, 1'b0);
    @(posedge ACLK); #1;
    axi_write(4'h8, 32'h00000000, 4'hF, 2'b00);

    // Misaligned accesses
`ifdef AXIL_CHAR_SLVERR_EN
    axi_read(4'h2, 32'h00000000, 2'b10);
    axi_write(4'h6, 32'h00000099, 4'hF, 2'b10);
    axi_read(4'h4, 32'h00000066, 2'b00);
`else
    axi_read(4'h2, 32'h11223344, 2'b00);
    axi_write(4'h6, 32'h00000099, 4'hF, 2'b00);
    axi_read(4'h4, 32'h00000099, 2'b00);
`endif

    repeat (4) @(posedge ACLK);
    #1;
    chk("rq_drained", rq.size(), 0);
    chk("bq_drained", bq.size(), 0);
    chk("cq_drained", cq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axil_char_write_40bit.md
Name: axil_char_write_40bit

Overview:
- AXI4-Lite slave (responder) that receives a 40-bit character word from the bus master as two register writes.
- On commit, it presents the word on a valid/ready streaming output.
- It is the target-side counterpart to the AXI4-Lite master traffic issued by the BFM test harness.
- It sits between the AXI interconnect and the character-display datapath.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; the register window is 0x0–0xC.

Ports:
- ACLK  in  1  clock
- ARESET  in  1  asynchronous, active-high reset
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
- S_AXI_AWPROT  in  3  ignored
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake
- S_AXI_WDATA  in  32  write data
- S_AXI_WSTRB  in  4  byte strobes
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake
- S_AXI_BRESP  out  2  write response
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
- S_AXI_ARPROT  in  3  ignored
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake
- S_AXI_RDATA  out  32  read data
- S_AXI_RRESP  out  2  read response
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read handshake
- char_data  out  40  committed character word
- char_valid  out  1  char_data valid
- char_ready  in  1  downstream accepts char_data

Behaviour:
- Reset (ARESET high, asynchronous):
  - All READY/VALID outputs are 0; BRESP, RRESP and RDATA are 0.
  - char_data and char_valid are 0.
  - All registers are 0.
- Register map (word address = addr[3:2]; addr[1:0] ignored):
  - 0x0 CHAR_LO, RW, bits 31:0.
  - 0x4 CHAR_HI, RW, bits 7:0; bits 31:8 read 0 and ignore writes.
  - 0x8 CTRL:
    - bit0 COMMIT is write-1-to-pulse and reads 0.
    - bit1 AUTO, RW: when set, a write to CHAR_HI also commits.
    - Other bits read 0.
  - 0xC STATUS, RO, writes ignored with OKAY:
    - [15:0] commit count, wraps 0xFFFF→0.
    - [30] pending = char_valid.
    - [31] OVF, sticky; cleared by writing CTRL with bit31=1.
- Byte strobes apply per byte to RW fields; WSTRB=0 performs no update but still responds OKAY.
- Write channel:
  - AW and W are accepted independently, in either order or in the same cycle.
  - AWREADY=1 when no AW is latched and BVALID=0; WREADY is defined the same way for W.
  - Once both AW and W are latched, the register update happens on that edge and BVALID rises on the next cycle with BRESP=OKAY.
  - BVALID holds until BREADY. The latches clear on the B handshake.
  - Single outstanding write.
- Read channel:
  - ARREADY=1 when RVALID=0.
  - On AR handshake, RDATA/RRESP are registered and RVALID rises on the next cycle (latency 1).
  - RDATA is held stable until RREADY.
  - Single outstanding read.
- Reads and writes proceed concurrently. A read of a register written in the same cycle returns the pre-write value.
- Commit trigger is a CTRL.COMMIT write, or an AUTO write to CHAR_HI.
  - char_data <= {CHAR_HI[7:0], CHAR_LO} using post-write values, char_valid <= 1, count++. This happens on the same edge as the register update.
  - char_valid holds until char_ready. char_data is stable while char_valid=1.
- Commit while char_valid=1 and char_ready=0:
  - The commit is dropped: char_data is unchanged and count is not incremented.
  - OVF sets.
- Commit in the same cycle as the char_ready handshake: the new word is loaded and char_valid stays 1.
- Reset mid-transaction aborts all handshakes; the master must reissue.

Optional Feature:
- Macro AXIL_CHAR_SLVERR_EN.
- Defined:
  - An access with addr[1:0]≠0 returns SLVERR (2'b10) on B or R.
  - Such a write performs no update or commit.
  - Such a read returns RDATA=0.
- Undefined: addr[1:0] is ignored and all responses are OKAY.

Test Plan:
- Write 0x0=0x11223344, 0x4=0x000000AA, read both back → 0x11223344 and 0x000000AA with RRESP=0; char_valid stays 0.
- Write CTRL=0x1 with char_ready=1 → char_data=0xAA11223344, char_valid pulses 1 cycle, STATUS[15:0]=1.
- Set AUTO (CTRL=0x2), char_ready=0, write CHAR_HI=0x55 → char_valid=1 with char_data=0x5511223344.
  - Then write CHAR_HI=0x66 → char_data unchanged, STATUS=0xC0000001.
  - Then write CTRL=0x80000002 → OVF cleared.
- Drive W three cycles before AW, and separately AW and W in the same cycle, with BREADY held 0 for 5 cycles → BVALID held, AWREADY=WREADY=0 until BREADY, single update each.
- Write CHAR_LO with WSTRB=0b0101 data 0xFFFFFFFF over 0x11223344 → reads 0x11FF33FF.
- With AXIL_CHAR_SLVERR_EN defined: read 0x2 → RRESP=2'b10, RDATA=0. Write to 0x6 → BRESP=2'b10, CHAR_HI unchanged.
